// File: rtl/csr_target_interface_waited_if.sv
// CSR request/response and local-access bundle for the waited CSR target.
// The master modport is the requester plus register block side; the slave modport is the target.
interface csr_target_interface_waited_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned SELECT_WIDTH = 16
);
  logic                    csr_request_valid;
  logic                    csr_request_read_not_write;
  logic [SELECT_WIDTH-1:0] csr_request_select;
  logic [ADDR_WIDTH-1:0]   csr_request_address;
  logic [DATA_WIDTH-1:0]   csr_request_data;
  logic                    csr_target_done;
  logic [DATA_WIDTH-1:0]   csr_read_data;
  logic                    csr_access_valid;
  logic                    csr_access_read_not_write;
  logic [ADDR_WIDTH-1:0]   csr_access_address;
  logic [DATA_WIDTH-1:0]   csr_access_data;
  logic                    csr_response_ack;
  logic                    csr_response_read_data_valid;
  logic [DATA_WIDTH-1:0]   csr_response_read_data;
  logic                    csr_response_error;

  modport master (
    output csr_request_valid, csr_request_read_not_write, csr_request_select,
           csr_request_address, csr_request_data, csr_target_done, csr_read_data,
    input  csr_access_valid, csr_access_read_not_write, csr_access_address,
           csr_access_data, csr_response_ack, csr_response_read_data_valid,
           csr_response_read_data, csr_response_error
  );

  modport slave (
    input  csr_request_valid, csr_request_read_not_write, csr_request_select,
           csr_request_address, csr_request_data, csr_target_done, csr_read_data,
    output csr_access_valid, csr_access_read_not_write, csr_access_address,
           csr_access_data, csr_response_ack, csr_response_read_data_valid,
           csr_response_read_data, csr_response_error
  );
endinterface

// File: rtl/csr_target_interface_waited.sv
// CSR target: accepts a selected request on the valid rising edge, holds the local access
// until the register block signals done, and aborts with an error after a cycle budget.
module csr_target_interface_waited #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned SELECT_WIDTH   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_WIDTH  = 5,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADC0DE
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SELECT_WIDTH-1:0]   csr_select,
  input  logic [SELECT_WIDTH-1:0]   csr_select_mask,
  csr_target_interface_waited_if.slave bus
);

  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST   = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0]    TIMEOUT_DATA_W = DATA_WIDTH'(TIMEOUT_DATA);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_e;

  state_e                   state_q, state_d;
  logic                     last_valid_q;
  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
  logic                     access_valid_q, access_valid_d;
  logic                     rnw_q, rnw_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     rdv_q, rdv_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     error_q, error_d;

  logic new_req;
  logic match;
  logic accept;
  logic done;
  logic timeout;

  assign new_req = bus.csr_request_valid & ~last_valid_q;
  assign match   = ((bus.csr_request_select ^ csr_select) & csr_select_mask) == '0;
  assign accept  = (state_q == IDLE) & new_req & match;
  assign done    = bus.csr_target_done;
  assign timeout = (count_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS: begin
        // done takes priority over the last timeout cycle
        if (done)         state_d = rnw_q ? RESPOND : IDLE;
        else if (timeout) state_d = RESPOND;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d        = count_q;
    access_valid_d = access_valid_q;
    rnw_d          = rnw_q;
    addr_d         = addr_q;
    data_d         = data_q;
    rdv_d          = rdv_q;
    rdata_d        = rdata_q;
    error_d        = error_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          access_valid_d = 1'b1;
          count_d        = '0;
          rnw_d          = bus.csr_request_read_not_write;
          addr_d         = bus.csr_request_address;
          data_d         = bus.csr_request_data;
        end
      end
      ACCESS: begin
        if (done) begin
          access_valid_d = 1'b0;
          if (rnw_q) begin
            rdv_d   = 1'b1;
            rdata_d = bus.csr_read_data;
          end
        end else if (timeout) begin
          access_valid_d = 1'b0;
          error_d        = 1'b1;
          if (rnw_q) begin
            rdv_d   = 1'b1;
            rdata_d = TIMEOUT_DATA_W;
          end
        end else begin
          count_d = count_q + TIMEOUT_WIDTH'(1);
        end
      end
      RESPOND: begin
        rdv_d   = 1'b0;
        rdata_d = '0;
        error_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_valid_q   <= 1'b0;
      count_q        <= '0;
      access_valid_q <= 1'b0;
      rnw_q          <= 1'b0;
      addr_q         <= '0;
      data_q         <= '0;
      rdv_q          <= 1'b0;
      rdata_q        <= '0;
      error_q        <= 1'b0;
    end else begin
      last_valid_q   <= bus.csr_request_valid;
      count_q        <= count_d;
      access_valid_q <= access_valid_d;
      rnw_q          <= rnw_d;
      addr_q         <= addr_d;
      data_q         <= data_d;
      rdv_q          <= rdv_d;
      rdata_q        <= rdata_d;
      error_q        <= error_d;
    end
  end

  assign bus.csr_access_valid             = access_valid_q;
  assign bus.csr_response_ack             = access_valid_q;
  assign bus.csr_access_read_not_write    = rnw_q;
  assign bus.csr_access_address           = addr_q;
  assign bus.csr_access_data              = data_q;
  assign bus.csr_response_read_data_valid = rdv_q;
  assign bus.csr_response_read_data       = rdata_q;
  assign bus.csr_response_error           = error_q;

endmodule

// File: tb/tb_csr_target_interface_waited.sv
// Directed bench for csr_target_interface_waited: a per-cycle vector table plus
// hand-written sequences for wait states, timeout, edge handling and reset.
module tb_csr_target_interface_waited;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] csr_select = 16'h1200;
  logic [15:0] csr_select_mask = 16'hFF00;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  csr_target_interface_waited_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(16)) bus ();

  csr_target_interface_waited #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(16),
    .TIMEOUT_CYCLES(16), .TIMEOUT_WIDTH(5), .TIMEOUT_DATA(32'hDEADC0DE)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_select(csr_select), .csr_select_mask(csr_select_mask),
    .bus(bus)
  );

  typedef struct {
    logic        valid;
    logic        rnw;
    logic [15:0] sel;
    logic [15:0] mask;
    logic [15:0] addr;
    logic [31:0] data;
    logic        done;
    logic [31:0] rdata;
    logic        exp_av;
    logic        exp_rdv;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    bus.csr_request_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_req(input logic rnw, input logic [15:0] addr, input logic [31:0] data);
    bus.csr_request_valid          = 1'b1;
    bus.csr_request_read_not_write = rnw;
    bus.csr_request_select         = 16'h12AB;
    bus.csr_request_address        = addr;
    bus.csr_request_data           = data;
    tick();
    bus.csr_request_valid = 1'b0;
  endtask

  // Counts access cycles, asserting done on cycle done_at (0 = never); bounded.
  task automatic run_access(input int done_at, output int cycles);
    cycles = 0;
    while (bus.csr_access_valid === 1'b1 && cycles < 40) begin
      cycles++;
      bus.csr_target_done = (cycles == done_at);
      tick();
    end
    bus.csr_target_done = 1'b0;
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 1'b1, 16'h12AB, 16'hFF00, 16'h0010, 32'h0,        1'b1, 32'h12345678, 1'b1, 1'b0, 32'h0,        1'b0, 16'h0010, 32'h0};
    vecs[1]  = '{1'b1, 1'b1, 16'h12AB, 16'hFF00, 16'h0010, 32'h0,        1'b1, 32'h12345678, 1'b0, 1'b1, 32'h12345678, 1'b0, 16'h0010, 32'h0};
    vecs[2]  = '{1'b0, 1'b1, 16'h12AB, 16'hFF00, 16'h0010, 32'h0,        1'b1, 32'h12345678, 1'b0, 1'b0, 32'h0,        1'b0, 16'h0010, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 16'h12AB, 16'hFF00, 16'h0004, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 16'h0004, 32'hA5A5A5A5};
    vecs[4]  = '{1'b0, 1'b0, 16'h12AB, 16'hFF00, 16'h0004, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'h0004, 32'hA5A5A5A5};
    vecs[5]  = '{1'b0, 1'b0, 16'h12AB, 16'hFF00, 16'h0004, 32'hA5A5A5A5, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'h0004, 32'hA5A5A5A5};
    vecs[6]  = '{1'b1, 1'b1, 16'h13AB, 16'hFF00, 16'h0020, 32'h11111111, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'h0004, 32'hA5A5A5A5};
    vecs[7]  = '{1'b0, 1'b1, 16'h13AB, 16'hFF00, 16'h0020, 32'h11111111, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'h0004, 32'hA5A5A5A5};
    vecs[8]  = '{1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'h0030, 32'h0,        1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        1'b0, 16'h0030, 32'h0};
    vecs[9]  = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0030, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 16'h0030, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0030, 32'h0,        1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0,        1'b0, 16'h0030, 32'h0};
    vecs[11] = '{1'b1, 1'b0, 16'h12AB, 16'hFF00, 16'h0040, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 16'h0040, 32'h5A5A5A5A};
    vecs[12] = '{1'b1, 1'b0, 16'h12AB, 16'hFF00, 16'h0040, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 16'h0040, 32'h5A5A5A5A};
    vecs[13] = '{1'b1, 1'b0, 16'h12AB, 16'hFF00, 16'h0040, 32'h5A5A5A5A, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'h0040, 32'h5A5A5A5A};
    vecs[14] = '{1'b1, 1'b0, 16'h12AB, 16'hFF00, 16'h0040, 32'h5A5A5A5A, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'h0040, 32'h5A5A5A5A};
    vecs[15] = '{1'b0, 1'b0, 16'h12AB, 16'hFF00, 16'h0040, 32'h5A5A5A5A, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 16'h0040, 32'h5A5A5A5A};

    bus.csr_request_valid          = 1'b0;
    bus.csr_request_read_not_write = 1'b0;
    bus.csr_request_select         = '0;
    bus.csr_request_address        = '0;
    bus.csr_request_data           = '0;
    bus.csr_target_done            = 1'b0;
    bus.csr_read_data              = '0;

    tick();
    tick();
    check("reset_av",   64'(bus.csr_access_valid), 64'd0);
    check("reset_ack",  64'(bus.csr_response_ack), 64'd0);
    check("reset_rdv",  64'(bus.csr_response_read_data_valid), 64'd0);
    check("reset_rd",   64'(bus.csr_response_read_data), 64'd0);
    check("reset_err",  64'(bus.csr_response_error), 64'd0);
    check("reset_addr", 64'(bus.csr_access_address), 64'd0);
    reset_n = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 16; i++) begin
      bus.csr_request_valid          = vecs[i].valid;
      bus.csr_request_read_not_write = vecs[i].rnw;
      bus.csr_request_select         = vecs[i].sel;
      csr_select_mask                = vecs[i].mask;
      bus.csr_request_address        = vecs[i].addr;
      bus.csr_request_data           = vecs[i].data;
      bus.csr_target_done            = vecs[i].done;
      bus.csr_read_data              = vecs[i].rdata;
      tick();
      check($sformatf("vec%0d_av", i),   64'(bus.csr_access_valid), 64'(vecs[i].exp_av));
      check($sformatf("vec%0d_ack", i),  64'(bus.csr_response_ack), 64'(vecs[i].exp_av));
      check($sformatf("vec%0d_rdv", i),  64'(bus.csr_response_read_data_valid), 64'(vecs[i].exp_rdv));
      check($sformatf("vec%0d_rd", i),   64'(bus.csr_response_read_data), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_err", i),  64'(bus.csr_response_error), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_addr", i), 64'(bus.csr_access_address), 64'(vecs[i].exp_addr));
      check($sformatf("vec%0d_data", i), 64'(bus.csr_access_data), 64'(vecs[i].exp_data));
    end
    bus.csr_target_done = 1'b0;
    csr_select_mask     = 16'hFF00;
    idle_cycles(2);

    // Wait states: write completes on the 4th access cycle
    start_req(1'b0, 16'h0004, 32'hA5A5A5A5);
    run_access(4, n);
    check("wait_cycles", 64'(n), 64'd4);
    check("wait_rdv",    64'(bus.csr_response_read_data_valid), 64'd0);
    check("wait_err",    64'(bus.csr_response_error), 64'd0);
    check("wait_data",   64'(bus.csr_access_data), 64'hA5A5A5A5);
    idle_cycles(2);

    // Timeout read
    bus.csr_read_data = 32'h77777777;
    start_req(1'b1, 16'h0070, 32'h0);
    run_access(0, n);
    check("to_rd_cycles", 64'(n), 64'd16);
    check("to_rd_err",    64'(bus.csr_response_error), 64'd1);
    check("to_rd_rdv",    64'(bus.csr_response_read_data_valid), 64'd1);
    check("to_rd_data",   64'(bus.csr_response_read_data), 64'hDEADC0DE);
    check("to_rd_ack",    64'(bus.csr_response_ack), 64'd0);
    tick();
    check("to_rd_err_clr", 64'(bus.csr_response_error), 64'd0);
    check("to_rd_rdv_clr", 64'(bus.csr_response_read_data_valid), 64'd0);
    check("to_rd_rd_clr",  64'(bus.csr_response_read_data), 64'd0);
    idle_cycles(2);

    // Timeout write
    start_req(1'b0, 16'h0074, 32'h00001234);
    run_access(0, n);
    check("to_wr_cycles", 64'(n), 64'd16);
    check("to_wr_err",    64'(bus.csr_response_error), 64'd1);
    check("to_wr_rdv",    64'(bus.csr_response_read_data_valid), 64'd0);
    tick();
    check("to_wr_err_clr", 64'(bus.csr_response_error), 64'd0);
    idle_cycles(2);

    // Done on the last budget cycle completes normally
    bus.csr_read_data = 32'h0BADF00D;
    start_req(1'b1, 16'h0080, 32'h0);
    run_access(16, n);
    check("edge_to_cycles", 64'(n), 64'd16);
    check("edge_to_err",    64'(bus.csr_response_error), 64'd0);
    check("edge_to_rdv",    64'(bus.csr_response_read_data_valid), 64'd1);
    check("edge_to_rd",     64'(bus.csr_response_read_data), 64'h0BADF00D);
    idle_cycles(2);

    // Second edge during ACCESS is dropped
    start_req(1'b0, 16'h0050, 32'h00000001);
    check("drop_av1", 64'(bus.csr_access_valid), 64'd1);
    tick();
    bus.csr_request_valid   = 1'b1;
    bus.csr_request_address = 16'h0060;
    bus.csr_request_data    = 32'h00000002;
    tick();
    check("drop_av3",   64'(bus.csr_access_valid), 64'd1);
    check("drop_addr3", 64'(bus.csr_access_address), 64'h0050);
    bus.csr_target_done = 1'b1;
    tick();
    bus.csr_target_done = 1'b0;
    check("drop_av_end", 64'(bus.csr_access_valid), 64'd0);
    tick();
    check("drop_no_new", 64'(bus.csr_access_valid), 64'd0);
    check("drop_addr",   64'(bus.csr_access_address), 64'h0050);
    check("drop_data",   64'(bus.csr_access_data), 64'h1);
    idle_cycles(2);

    // Asynchronous reset mid-access
    start_req(1'b1, 16'h0090, 32'h0);
    check("rst_pre_av", 64'(bus.csr_access_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_av",   64'(bus.csr_access_valid), 64'd0);
    check("rst_ack",  64'(bus.csr_response_ack), 64'd0);
    check("rst_rdv",  64'(bus.csr_response_read_data_valid), 64'd0);
    check("rst_err",  64'(bus.csr_response_error), 64'd0);
    check("rst_addr", 64'(bus.csr_access_address), 64'd0);
    tick();
    reset_n = 1'b1;
    idle_cycles(2);
    check("rst_after_err", 64'(bus.csr_response_error), 64'd0);
    bus.csr_target_done = 1'b1;
    bus.csr_read_data   = 32'h600DCAFE;
    start_req(1'b1, 16'h00A0, 32'h0);
    check("post_rst_av", 64'(bus.csr_access_valid), 64'd1);
    tick();
    check("post_rst_av_drop", 64'(bus.csr_access_valid), 64'd0);
    check("post_rst_rdv",     64'(bus.csr_response_read_data_valid), 64'd1);
    check("post_rst_rd",      64'(bus.csr_response_read_data), 64'h600DCAFE);
    check("post_rst_err",     64'(bus.csr_response_error), 64'd0);
    bus.csr_target_done = 1'b0;
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
